// File: rtl/sfq_arb_pkg.sv
// sfq_arb_pkg
// Shared types and constants for the SFQ splitter-tree arbiter.
//   arb_state_t : arbiter FSM state encoding
//   VIOL_CNT_W  : width of the optional violation counter
//   calc_id_w() : width of a requester index for a given requester count
package sfq_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } arb_state_t;

    localparam int VIOL_CNT_W = 8;

    function automatic int calc_id_w(input int n_req);
        return (n_req <= 2) ? 1 : $clog2(n_req);
    endfunction

endpackage

// File: rtl/sfq_rr_picker.sv
// sfq_rr_picker
// Combinational round-robin select. The search starts at ptr and wraps,
// so the first active request at or after ptr wins.
// Ports:
//   req    in  [N_REQ-1:0]  level requests
//   ptr    in  [ID_W-1:0]   highest-priority index this cycle
//   gnt    out [N_REQ-1:0]  one-hot winner (all zero when no request)
//   gnt_id out [ID_W-1:0]   index of the winner
//   valid  out              at least one request present
module sfq_rr_picker #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             valid
);

    // Two passes instead of a modulo index: first the indices at or above
    // ptr, then the wrapped ones below it.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        valid  = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!valid && req[j] && (j >= int'(ptr))) begin
                valid  = 1'b1;
                gnt[j] = 1'b1;
                gnt_id = ID_W'(j);
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!valid && req[j] && (j < int'(ptr))) begin
                valid  = 1'b1;
                gnt[j] = 1'b1;
                gnt_id = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/sfq_splitter_arbiter.sv
// sfq_splitter_arbiter
// Shares one SFQ splitter-tree root between N_REQ requesters. Each toggle of
// drive is one SFQ pulse; after every pulse a hold-off window keeps the next
// toggle at least HOLDOFF+1 cycles away. Unarbitrated raw pulses landing in
// that window are dropped and flagged on the sticky err output.
// Optional build macro: SPLITTER_ARB_VIOL_CNT_EN adds the viol_cnt output.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   req        in   [N_REQ-1:0] level requests, held until ack
//   ack        out  [N_REQ-1:0] one-hot, one-cycle grant
//   raw_pulse  in   unarbitrated pulse injection
//   drive      out  toggle line to splitter root
//   active_id  out  [ID_W-1:0] last granted requester
//   busy       out  high in ISSUE or HOLD
//   err        out  sticky timing-violation flag
//   err_clr    in   clears err (a simultaneous violation wins)
//   viol_cnt   out  [7:0] saturating violation count (macro builds only)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no pulse in flight; raw_pulse or a request may start one
// ISSUE | grant cycle: ack/drive/active_id reflect the pulse just issued
// HOLD  | hold-off window counting down; new pulses are forbidden
module sfq_splitter_arbiter
    import sfq_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int HOLDOFF = 5,
    parameter int ID_W    = calc_id_w(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] ack,
    input  logic             raw_pulse,
    output logic             drive,
    output logic [ID_W-1:0]  active_id,
    output logic             busy,
    output logic             err,
    input  logic             err_clr
`ifdef SPLITTER_ARB_VIOL_CNT_EN
    ,
    output logic [VIOL_CNT_W-1:0] viol_cnt
`endif
);

    localparam int CNT_W = $clog2(HOLDOFF + 1);

    arb_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_drive;
    logic [N_REQ-1:0]  r_ack;
    logic [ID_W-1:0]   r_active_id;
    logic [ID_W-1:0]   r_rr_ptr;
    logic              r_err;

    arb_state_t        w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_drive_nxt;
    logic [N_REQ-1:0]  w_ack_nxt;
    logic [ID_W-1:0]   w_id_nxt;
    logic [ID_W-1:0]   w_ptr_nxt;
    logic              w_viol;

    logic [N_REQ-1:0]  w_gnt;
    logic [ID_W-1:0]   w_gnt_id;
    logic              w_gnt_valid;
    logic [ID_W-1:0]   w_ptr_after_gnt;

    sfq_rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .req    (req),
        .ptr    (r_rr_ptr),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id),
        .valid  (w_gnt_valid)
    );

    assign w_ptr_after_gnt = (w_gnt_id == ID_W'(N_REQ - 1)) ? '0
                                                             : w_gnt_id + ID_W'(1);

    // Any raw pulse outside IDLE would break the splitter's spacing.
    assign w_viol = raw_pulse && (r_state != ST_IDLE);

    // The pulse is registered on the edge that enters ISSUE, so drive, ack and
    // active_id are all visible during the ISSUE cycle. That cycle counts as
    // one hold-off cycle, hence HOLDOFF-1 is loaded on leaving ISSUE, while a
    // raw pulse (which skips ISSUE) loads the full HOLDOFF.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_drive_nxt = r_drive;
        w_ack_nxt   = '0;
        w_id_nxt    = r_active_id;
        w_ptr_nxt   = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (raw_pulse) begin
                    w_drive_nxt = ~r_drive;
                    w_cnt_nxt   = CNT_W'(HOLDOFF);
                    w_state_nxt = ST_HOLD;
                end else if (w_gnt_valid) begin
                    w_state_nxt = ST_ISSUE;
                    w_drive_nxt = ~r_drive;
                    w_ack_nxt   = w_gnt;
                    w_id_nxt    = w_gnt_id;
                    w_ptr_nxt   = w_ptr_after_gnt;
                end
            end
            ST_ISSUE: begin
                w_cnt_nxt   = CNT_W'(HOLDOFF - 1);
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (r_cnt == '0) begin
                    if (w_gnt_valid) begin
                        w_state_nxt = ST_ISSUE;
                        w_drive_nxt = ~r_drive;
                        w_ack_nxt   = w_gnt;
                        w_id_nxt    = w_gnt_id;
                        w_ptr_nxt   = w_ptr_after_gnt;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_drive     <= 1'b0;
            r_ack       <= '0;
            r_active_id <= '0;
            r_rr_ptr    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_drive     <= w_drive_nxt;
            r_ack       <= w_ack_nxt;
            r_active_id <= w_id_nxt;
            r_rr_ptr    <= w_ptr_nxt;
        end
    end

    // Set has priority over clear so a violation is never lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_viol) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

`ifdef SPLITTER_ARB_VIOL_CNT_EN
    logic [VIOL_CNT_W-1:0] r_viol_cnt;

    // A clear coinciding with a violation restarts the count at one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_viol_cnt <= '0;
        end else if (err_clr) begin
            r_viol_cnt <= w_viol ? VIOL_CNT_W'(1) : '0;
        end else if (w_viol && (r_viol_cnt != {VIOL_CNT_W{1'b1}})) begin
            r_viol_cnt <= r_viol_cnt + VIOL_CNT_W'(1);
        end
    end

    assign viol_cnt = r_viol_cnt;
`endif

    assign ack       = r_ack;
    assign drive     = r_drive;
    assign active_id = r_active_id;
    assign busy      = (r_state != ST_IDLE);
    assign err       = r_err;

endmodule

// File: tb/tb_sfq_splitter_arbiter.sv
module tb_sfq_splitter_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] ack;
    logic       raw_pulse;
    logic       drive;
    logic [1:0] active_id;
    logic       busy;
    logic       err;
    logic       err_clr;
`ifdef SPLITTER_ARB_VIOL_CNT_EN
    logic [7:0] viol_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic drive_exp = 1'b0;

    sfq_splitter_arbiter #(
        .N_REQ   (4),
        .HOLDOFF (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .ack       (ack),
        .raw_pulse (raw_pulse),
        .drive     (drive),
        .active_id (active_id),
        .busy      (busy),
        .err       (err),
        .err_clr   (err_clr)
`ifdef SPLITTER_ARB_VIOL_CNT_EN
        ,
        .viol_cnt  (viol_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One active edge, then settle at the falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        drive_exp = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ack"},    32'(ack),       32'h0);
        check_val({tag, "_drive"},  32'(drive),     32'h0);
        check_val({tag, "_id"},     32'(active_id), 32'h0);
        check_val({tag, "_busy"},   32'(busy),      32'h0);
        check_val({tag, "_err"},    32'(err),       32'h0);
    endtask

    // Idle out a hold-off window: n HOLD cycles then the drop to IDLE.
    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int exp_ids [5] = '{0, 1, 2, 3, 0};

        req       = '0;
        raw_pulse = 1'b0;
        err_clr   = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);

        // Reset state
        do_reset();
        check_reset_outputs("rst");
`ifdef SPLITTER_ARB_VIOL_CNT_EN
        check_val("rst_vcnt", 32'(viol_cnt), 32'h0);
`endif

        // Single request: grant one cycle later, busy for 1+5 cycles
        req = 4'b0010;
        tick();
        drive_exp = ~drive_exp;
        check_val("single_ack",   32'(ack),       32'h2);
        check_val("single_drive", 32'(drive),     32'(drive_exp));
        check_val("single_id",    32'(active_id), 32'h1);
        check_val("single_busy",  32'(busy),      32'h1);
        req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("single_hold_busy", 32'(busy), 32'h1);
            check_val("single_hold_ack",  32'(ack),  32'h0);
        end
        tick();
        check_val("single_idle_busy", 32'(busy), 32'h0);

        // All requesting from a fresh pointer: grants 0,1,2,3,0, period 6
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            drive_exp = ~drive_exp;
            check_val("rr_ack",   32'(ack),       32'(4'b0001 << exp_ids[g]));
            check_val("rr_id",    32'(active_id), 32'(exp_ids[g]));
            check_val("rr_drive", 32'(drive),     32'(drive_exp));
            for (int h = 0; h < 5; h++) begin
                tick();
                check_val("rr_spacing_drive", 32'(drive), 32'(drive_exp));
                check_val("rr_spacing_ack",   32'(ack),   32'h0);
            end
        end
        req = 4'b0000;
        tick();
        check_val("rr_idle_busy", 32'(busy), 32'h0);

        // Raw priority: raw wins in IDLE, deferred req granted 6 cycles later
        raw_pulse = 1'b1;
        req       = 4'b0100;
        tick();
        drive_exp = ~drive_exp;
        raw_pulse = 1'b0;
        check_val("raw_drive", 32'(drive), 32'(drive_exp));
        check_val("raw_ack",   32'(ack),   32'h0);
        check_val("raw_busy",  32'(busy),  32'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("raw_hold_ack", 32'(ack), 32'h0);
        end
        tick();
        drive_exp = ~drive_exp;
        check_val("raw_deferred_ack",   32'(ack),       32'h4);
        check_val("raw_deferred_id",    32'(active_id), 32'h2);
        check_val("raw_deferred_drive", 32'(drive),     32'(drive_exp));
        check_val("raw_err",            32'(err),       32'h0);
        req = 4'b0000;
        drain(6);
        check_val("raw_idle_busy", 32'(busy), 32'h0);

        // Violation on the 3rd HOLD cycle
        req = 4'b0001;
        tick();
        drive_exp = ~drive_exp;
        check_val("viol_issue_ack", 32'(ack), 32'h1);
        req = 4'b0000;
        tick();
        tick();
        tick();
        raw_pulse = 1'b1;
        tick();
        raw_pulse = 1'b0;
        check_val("viol_err",   32'(err),   32'h1);
        check_val("viol_drive", 32'(drive), 32'(drive_exp));
`ifdef SPLITTER_ARB_VIOL_CNT_EN
        check_val("viol_vcnt1", 32'(viol_cnt), 32'h1);
`endif
        tick();
        check_val("viol_sched_busy", 32'(busy), 32'h1);
        tick();
        check_val("viol_sched_idle", 32'(busy), 32'h0);
        check_val("viol_sticky",     32'(err),  32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_val("viol_clr", 32'(err), 32'h0);
`ifdef SPLITTER_ARB_VIOL_CNT_EN
        check_val("viol_vcnt0", 32'(viol_cnt), 32'h0);
`endif

        // Violation in ISSUE with simultaneous clear: set wins
        req = 4'b0010;
        tick();
        drive_exp = ~drive_exp;
        check_val("setwin_ack", 32'(ack), 32'h2);
        req       = 4'b0000;
        raw_pulse = 1'b1;
        err_clr   = 1'b1;
        tick();
        raw_pulse = 1'b0;
        err_clr   = 1'b0;
        check_val("setwin_err",   32'(err),   32'h1);
        check_val("setwin_drive", 32'(drive), 32'(drive_exp));
`ifdef SPLITTER_ARB_VIOL_CNT_EN
        check_val("setwin_vcnt", 32'(viol_cnt), 32'h1);
`endif
        drain(5);
        check_val("setwin_idle", 32'(busy), 32'h0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_val("setwin_clr", 32'(err), 32'h0);

        // Reset mid-HOLD with req[3] held
        req = 4'b1000;
        tick();
        drive_exp = ~drive_exp;
        check_val("rsthold_ack",   32'(ack),   32'h8);
        check_val("rsthold_drive", 32'(drive), 32'(drive_exp));
        tick();
        tick();
        check_val("rsthold_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive_exp = 1'b0;
        check_reset_outputs("rsthold");
        tick();
        drive_exp = ~drive_exp;
        check_val("rsthold_regrant_ack",   32'(ack),       32'h8);
        check_val("rsthold_regrant_id",    32'(active_id), 32'h3);
        check_val("rsthold_regrant_drive", 32'(drive),     32'(drive_exp));
        req = 4'b0000;
        drain(6);

`ifdef SPLITTER_ARB_VIOL_CNT_EN
        // Saturation: raw held high gives six violations every seven cycles
        raw_pulse = 1'b1;
        for (int i = 0; i < 400; i++) tick();
        raw_pulse = 1'b0;
        check_val("sat_vcnt", 32'(viol_cnt), 32'hFF);
        check_val("sat_err",  32'(err),      32'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
